// File: rtl/sudoku_checker.sv
// Sudoku board checker: snapshots an N x N board on a start edge, then scans rows,
// columns and boxes one group per clock, reporting pass/fail and the first failing group.

module sudoku_lane #(
    parameter int N      = 4,
    parameter int CELL_W = 3
) (
    input  logic [CELL_W-1:0] v,
    output logic [N-1:0]      onehot,
    output logic              bad
);
    always_comb begin
        bad = (v == '0) || (int'(v) > N);
        for (int j = 0; j < N; j++) onehot[j] = (int'(v) == j + 1);
    end
endmodule

module sudoku_checker #(
    parameter int BOX    = 2,
    parameter int CELL_W = 3
) (
    input  logic                             clka,
    input  logic                             restart_n,
    input  logic                             start,
    input  logic [BOX**4*CELL_W-1:0]         board,
    output logic                             busy,
    output logic                             done,
    output logic                             solved,
    output logic [1:0]                       fail_type,
    output logic [$clog2(BOX*BOX)-1:0]       fail_idx
);
    localparam int N  = BOX * BOX;
    localparam int IW = $clog2(N);

    // State encodings double as the fail_type code of the group being scanned.
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_ROW = 2'b01, S_COL = 2'b10, S_BOX = 2'b11} state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    start_d;
    logic [N*N*CELL_W-1:0]   snap;
    logic                    snap_ld;
    logic                    busy_nxt, done_nxt, solved_nxt;
    logic [1:0]              ft_nxt;
    logic [IW-1:0]           fi_nxt;

    logic [N-1:0][CELL_W-1:0] lane_v;
    logic [N-1:0][N-1:0]      lane_oh;
    logic [N-1:0]             lane_bad;
    logic [N-1:0]             mask;
    logic                     any_bad, grp_ok;

    function automatic int cell_of(input state_t st, input int g, input int k);
        int r, c;
        case (st)
            S_COL:   begin r = k; c = g; end
            S_BOX:   begin r = BOX * (g / BOX) + k / BOX; c = BOX * (g % BOX) + k % BOX; end
            default: begin r = g; c = k; end
        endcase
        return r * N + c;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++)
            lane_v[k] = snap[CELL_W*cell_of(state, int'(idx), k) +: CELL_W];
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        sudoku_lane #(.N(N), .CELL_W(CELL_W)) u_lane (
            .v      (lane_v[k]),
            .onehot (lane_oh[k]),
            .bad    (lane_bad[k])
        );
    end

    // A full mask with no illegal cells means every digit appears exactly once.
    always_comb begin
        mask    = '0;
        any_bad = 1'b0;
        for (int k = 0; k < N; k++) begin
            mask    = mask | lane_oh[k];
            any_bad = any_bad | lane_bad[k];
        end
        grp_ok = ~any_bad & (&mask);
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        solved_nxt = solved;
        ft_nxt     = fail_type;
        fi_nxt     = fail_idx;
        snap_ld    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !start_d) begin
                    snap_ld    = 1'b1;
                    solved_nxt = 1'b0;
                    ft_nxt     = 2'b00;
                    fi_nxt     = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_ROW;
                    idx_nxt    = '0;
                end
            end
            default: begin
                if (!grp_ok) begin
                    done_nxt   = 1'b1;
                    solved_nxt = 1'b0;
                    ft_nxt     = state;
                    fi_nxt     = idx;
                    busy_nxt   = 1'b0;
                    state_nxt  = S_IDLE;
                    idx_nxt    = '0;
                end else if (idx == IW'(N - 1)) begin
                    idx_nxt = '0;
                    case (state)
                        S_ROW: state_nxt = S_COL;
                        S_COL: state_nxt = S_BOX;
                        default: begin
                            done_nxt   = 1'b1;
                            solved_nxt = 1'b1;
                            ft_nxt     = 2'b00;
                            busy_nxt   = 1'b0;
                            state_nxt  = S_IDLE;
                        end
                    endcase
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            start_d   <= 1'b0;
            snap      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            solved    <= 1'b0;
            fail_type <= 2'b00;
            fail_idx  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            start_d   <= start;
            busy      <= busy_nxt;
            done      <= done_nxt;
            solved    <= solved_nxt;
            fail_type <= ft_nxt;
            fail_idx  <= fi_nxt;
            if (snap_ld) snap <= board;
        end
    end
endmodule

// File: tb/tb_sudoku_checker.sv
// Directed bench for sudoku_checker (BOX=2): latency, result and control-path checks.

module tb_sudoku_checker;
    localparam int BOX    = 2;
    localparam int CELL_W = 3;
    localparam int N      = 4;

    logic              clka = 1'b0;
    logic              restart_n;
    logic              start;
    logic [N*N*CELL_W-1:0] board;
    logic              busy, done, solved;
    logic [1:0]        fail_type;
    logic [1:0]        fail_idx;

    int checks   = 0;
    int failures = 0;

    sudoku_checker #(.BOX(BOX), .CELL_W(CELL_W)) dut (
        .clka      (clka),
        .restart_n (restart_n),
        .start     (start),
        .board     (board),
        .busy      (busy),
        .done      (done),
        .solved    (solved),
        .fail_type (fail_type),
        .fail_idx  (fail_idx)
    );

    always #5 clka = ~clka;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Rows given as 4 hex digits, leftmost digit = column 0.
    function automatic logic [N*N*CELL_W-1:0] mk(input int r0, input int r1, input int r2, input int r3);
        logic [N*N*CELL_W-1:0] b;
        int rows[4];
        rows = '{r0, r1, r2, r3};
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[CELL_W*(r*4+c) +: CELL_W] = CELL_W'((rows[r] >> (4*(3-c))) & 'hF);
        return b;
    endfunction

    function automatic logic [N*N*CELL_W-1:0] set_cell(input logic [N*N*CELL_W-1:0] b,
                                                       input int r, input int c, input int v);
        logic [N*N*CELL_W-1:0] o;
        o = b;
        o[CELL_W*(r*4+c) +: CELL_W] = CELL_W'(v);
        return o;
    endfunction

    // Pulses start, then counts edges after the accepted edge until done.
    task automatic run(input string tag, input int lat, input int sv, input int ft, input int fi);
        int cnt;
        @(negedge clka) start = 1'b1;
        @(posedge clka); #1;
        chk({tag, "_busy_k"}, int'(busy), 1);
        chk({tag, "_solved_clr"}, int'(solved), 0);
        @(negedge clka) start = 1'b0;
        cnt = 0;
        while (cnt < 40) begin
            @(posedge clka); #1;
            cnt++;
            if (done) break;
        end
        chk({tag, "_latency"}, cnt, lat);
        chk({tag, "_solved"}, int'(solved), sv);
        chk({tag, "_fail_type"}, int'(fail_type), ft);
        chk({tag, "_fail_idx"}, int'(fail_idx), fi);
        chk({tag, "_busy_done"}, int'(busy), 0);
        @(posedge clka); #1;
        chk({tag, "_done_drop"}, int'(done), 0);
        chk({tag, "_hold"}, int'({solved, fail_type, fail_idx}), (sv << 4) | (ft << 2) | fi);
    endtask

    logic [N*N*CELL_W-1:0] valid_b;

    initial begin
        int ndone, first;
        valid_b   = mk('h1234, 'h3412, 'h2143, 'h4321);
        board     = valid_b;
        start     = 1'b0;
        restart_n = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        chk("rst_outs", int'({busy, done, solved, fail_type, fail_idx}), 0);
        @(negedge clka) restart_n = 1'b1;
        @(posedge clka); #1;

        run("valid", 12, 1, 0, 0);

        board = set_cell(valid_b, 0, 0, 0);
        run("empty00", 1, 0, 1, 0);

        board = mk('h2134, 'h3412, 'h2143, 'h4321);
        run("colswap", 5, 0, 2, 0);

        board = mk('h1234, 'h2341, 'h3412, 'h4123);
        run("latin", 9, 0, 3, 0);

        board = set_cell(valid_b, 2, 3, 5);
        run("illegal23", 3, 0, 1, 2);

        // Held start with a second rising edge mid-scan; board corrupted after k.
        board = valid_b;
        @(negedge clka) start = 1'b1;
        @(posedge clka); #1;
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clka);
            start = (c < 20 && c != 5);
            if (c == 1) board = '0;
            @(posedge clka); #1;
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        chk("held_ndone", ndone, 1);
        chk("held_first", first, 12);
        chk("held_solved", int'(solved), 1);
        chk("held_ft", int'(fail_type), 0);

        // Reset mid-scan: outputs clear asynchronously and the scan never completes.
        board = valid_b;
        @(negedge clka) start = 1'b1;
        @(posedge clka); #1;
        @(negedge clka) start = 1'b0;
        repeat (4) @(posedge clka);
        @(negedge clka) restart_n = 1'b0;
        #1;
        chk("midrst_outs", int'({busy, done, solved, fail_type, fail_idx}), 0);
        @(negedge clka) restart_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clka); #1;
            if (done || busy) ndone++;
        end
        chk("midrst_nodone", ndone, 0);

        run("after_rst", 12, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
